// File: rtl/stack_return_unit_pkg.sv
// Shared types and constants for the stack return unit (RET / RETS / RETD).
package stack_return_unit_pkg;

    // Default geometry of the data RAM and the stack pointer.
    localparam int RAM_ADDR_W_DEF = 12;
    localparam int SP_W_DEF       = 8;

    // The stack lives in the first 256-nibble page of data RAM.
    localparam logic [3:0] STACK_PAGE = 4'h0;

    // Return flavours; encoding 3 is reserved and executes as a plain RET.
    typedef enum logic [1:0] {
        RK_RET  = 2'd0,
        RK_RETS = 2'd1,
        RK_RETD = 2'd2
    } ret_kind_t;

    // Pop sequence: three reads, a capture cycle, two optional writes, done.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CAP  = 3'd4,
        ST_WR0  = 3'd5,
        ST_WR1  = 3'd6,
        ST_DONE = 3'd7
    } ret_state_t;

    // Map the raw kind field onto a legal return flavour.
    function automatic ret_kind_t decode_kind(input logic [1:0] k);
        ret_kind_t r;
        case (k)
            2'd1:    r = RK_RETS;
            2'd2:    r = RK_RETD;
            default: r = RK_RET;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_return_unit.sv
// Stack return unit: pops the 3-nibble return address from the stack page,
// rebuilds PC/NP/SP, and for RETD also stores the immediate byte at M(X).
//
// Handshake: start is a one-cycle request honoured only while idle (busy low);
// busy stays high from the cycle after the accepted start through the done
// cycle, and done is a one-cycle pulse during which pc_out/np_out/sp_out/x_out
// carry the result. Requests arriving while busy are dropped, not queued.
module stack_return_unit
    import stack_return_unit_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
    parameter int SP_W       = SP_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            kind,
    input  logic [7:0]            imm,
    input  logic [12:0]           pc_in,
    input  logic [SP_W-1:0]       sp_in,
    input  logic [11:0]           x_in,
    output logic [RAM_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [3:0]            mem_wdata,
    input  logic [3:0]            mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [12:0]           pc_out,
    output logic [4:0]            np_out,
    output logic [SP_W-1:0]       sp_out,
    output logic [11:0]           x_out,
    output logic [2:0]            dbg_state
);

    // Operation context latched at the start edge.
    ret_state_t      state_q;
    ret_kind_t       kind_q;
    logic [7:0]      imm_q;
    logic            bank_q;
    logic [SP_W-1:0] sp_q;
    logic [11:0]     x_q;

    // Popped nibbles (PCP comes straight from mem_rdata in CAP).
    logic [3:0]      pcsl_q;
    logic [3:0]      pcsh_q;

    // Registered outputs.
    logic [RAM_ADDR_W-1:0] mem_addr_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic [3:0]            mem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic [12:0]           pc_q;
    logic [4:0]            np_q;
    logic [SP_W-1:0]       sp_out_q;
    logic [11:0]           x_out_q;

    // Next-state values for the result registers, valid in CAP.
    logic [11:0]     popped_d;
    logic [12:0]     pc_d;
    logic [4:0]      np_d;
    logic [SP_W-1:0] sp_d;
    logic [11:0]     x_d;

    // Address helpers; all stack arithmetic wraps inside the page.
    logic [SP_W-1:0] sp_p1;
    logic [SP_W-1:0] sp_p2;
    logic [7:0]      xl_p1;
    logic [7:0]      xl_p2;

    // Only the bank bit of the incoming PC matters.
    logic [11:0]     unused_pc_low;

    assign unused_pc_low = pc_in[11:0];

    assign sp_p1 = sp_q + SP_W'(1);
    assign sp_p2 = sp_q + SP_W'(2);
    assign xl_p1 = x_q[7:0] + 8'd1;
    assign xl_p2 = x_q[7:0] + 8'd2;

    // Result computation from the three popped nibbles.
    always_comb begin
        popped_d = {mem_rdata, pcsh_q, pcsl_q};
        pc_d     = {bank_q, popped_d};
        if (kind_q == RK_RETS) begin
            pc_d = {bank_q, popped_d + 12'd1};
        end
        np_d = {bank_q, mem_rdata};
        sp_d = sp_q + SP_W'(3);
        x_d  = x_q;
        if (kind_q == RK_RETD) begin
            x_d = {x_q[11:8], xl_p2};
        end
    end

    // Sequencer: walks the pop/write sequence and drives registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= RK_RET;
            imm_q       <= '0;
            bank_q      <= 1'b0;
            sp_q        <= '0;
            x_q         <= '0;
            pcsl_q      <= '0;
            pcsh_q      <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pc_q        <= '0;
            np_q        <= '0;
            sp_out_q    <= '0;
            x_out_q     <= '0;
        end else begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        kind_q     <= decode_kind(kind);
                        imm_q      <= imm;
                        bank_q     <= pc_in[12];
                        sp_q       <= sp_in;
                        x_q        <= x_in;
                        busy_q     <= 1'b1;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {STACK_PAGE, sp_in};
                        state_q    <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {STACK_PAGE, sp_p1};
                    state_q    <= ST_RD1;
                end
                ST_RD1: begin
                    pcsl_q     <= mem_rdata;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {STACK_PAGE, sp_p2};
                    state_q    <= ST_RD2;
                end
                ST_RD2: begin
                    pcsh_q  <= mem_rdata;
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    pc_q     <= pc_d;
                    np_q     <= np_d;
                    sp_out_q <= sp_d;
                    x_out_q  <= x_d;
                    if (kind_q == RK_RETD) begin
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= x_q;
                        mem_wdata_q <= imm_q[3:0];
                        state_q     <= ST_WR0;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_WR0: begin
                    mem_wr_q    <= 1'b1;
                    mem_addr_q  <= {x_q[11:8], xl_p1};
                    mem_wdata_q <= imm_q[7:4];
                    state_q     <= ST_WR1;
                end
                ST_WR1: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pc_out    = pc_q;
    assign np_out    = np_q;
    assign sp_out    = sp_out_q;
    assign x_out     = x_out_q;
    assign dbg_state = state_q;

endmodule
